// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the AHB-Lite requesters and the bus arbiter.
// The arbiter connects through the slave modport; the requester/bus side uses master.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
) ();
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] M_HBUSREQ;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] M_HGRANT;
  logic [MW-1:0]          HMASTER;
  logic [MW-1:0]          HMASTER_D;
  logic                   arb_busy;

  modport master (
    output M_HBUSREQ, HREADY,
    input  M_HGRANT, HMASTER, HMASTER_D, arb_busy
  );

  modport slave (
    input  M_HBUSREQ, HREADY,
    output M_HGRANT, HMASTER, HMASTER_D, arb_busy
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Single-bus AHB-Lite arbiter: one-hot grant, address/data-phase owner indices, tenure limit.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin selection; fixed lowest-index priority otherwise.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input logic              clk,
  input logic              rst,
  ahb_bus_arbiter_if.slave bus
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          master_q, master_d;
  logic [MW-1:0]          master_dp_q, master_dp_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] req, others;
  logic [MW-1:0]          start, win_all, win_oth, win;
  logic                   owner_req, any_req, any_oth, hold_expired, do_grant;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [MW-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif

  // First set bit at or after 'start', wrapping; start=0 gives fixed lowest-index priority.
  function automatic logic [MW-1:0] pick(input logic [NUM_MASTERS-1:0] r,
                                         input logic [MW-1:0] from);
    logic [MW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(from) + k) % NUM_MASTERS;
      if (!found && r[idx]) begin
        w     = MW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign req          = bus.M_HBUSREQ;
  assign others       = req & ~grant_q;
  assign owner_req    = |(req & grant_q);
  assign any_req      = |req;
  assign any_oth      = |others;
  assign win_all      = pick(req, start);
  assign win_oth      = pick(others, start);
  assign hold_expired = (MAX_HOLD != 0) && (int'(cnt_q) == MAX_HOLD - 1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    master_d    = master_q;
    master_dp_d = master_dp_q;
    cnt_d       = cnt_q;
    win         = '0;
    do_grant    = 1'b0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    if (bus.HREADY) begin
      master_dp_d = master_q;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            do_grant = 1'b1;
            win      = win_all;
          end
        end
        OWNED: begin
          // A release outranks preemption; the owner's bit is already clear in req here.
          if (!owner_req) begin
            if (any_req) begin
              do_grant = 1'b1;
              win      = win_all;
            end else begin
              state_d  = IDLE;
              grant_d  = '0;
              master_d = DEF_IDX;
              cnt_d    = '0;
            end
          end else if (hold_expired && any_oth) begin
            do_grant = 1'b1;
            win      = win_oth;
          end else if (int'(cnt_q) < MAX_HOLD) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
      if (do_grant) begin
        state_d  = OWNED;
        grant_d  = NUM_MASTERS'(1) << win;
        master_d = win;
        cnt_d    = '0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        ptr_d    = MW'((int'(win) + 1) % NUM_MASTERS);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      master_q    <= DEF_IDX;
      master_dp_q <= DEF_IDX;
      cnt_q       <= '0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      master_q    <= master_d;
      master_dp_q <= master_dp_d;
      cnt_q       <= cnt_d;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.M_HGRANT  = grant_q;
  assign bus.HMASTER   = master_q;
  assign bus.HMASTER_D = master_dp_q;
  assign bus.arb_busy  = (state_q == OWNED);
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Arbitrates a single AHB-Lite style shared bus between up to NUM_MASTERS requesters (instruction-fetch port, load/store port, debug/DMA).
- Each requester is a CPU-side AHB interface. It raises HBUSREQ and holds its transfer until it sees HGRANT.
- The arbiter issues a one-hot grant and drives the address-phase and data-phase master indices used by the interconnect muxes.
- Grants change only on HREADY-qualified cycles. A tenure limit prevents one master from starving the others.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- DEFAULT_MASTER, 0, index driven on HMASTER when no master owns the bus.
- MAX_HOLD, 16, maximum HREADY-qualified cycles an owner keeps the bus while another master requests. 0 disables preemption.
- MW, $clog2(NUM_MASTERS) (minimum 1), width of master index (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- M_HBUSREQ  in  NUM_MASTERS  per-master bus request, bit i from master i.
- HREADY  in  1  bus-ready from the slave mux; 1 = current data phase completes this cycle.
- M_HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  MW  address-phase owner index, registered.
- HMASTER_D  out  MW  data-phase owner index (HMASTER delayed by one HREADY-qualified cycle), used for the HWDATA/HRDATA mux.
- arb_busy  out  1  1 while any master holds a grant.

Behaviour:
- Reset (rst=1 at a clk edge):
  - M_HGRANT=0, HMASTER=DEFAULT_MASTER, HMASTER_D=DEFAULT_MASTER, arb_busy=0.
  - State IDLE, tenure counter=0, priority pointer=0.
  - A reset asserted mid-tenure drops the grant at that same edge. No partial state survives.
- Update rule: all state and outputs update only on edges where HREADY=1. With HREADY=0 everything holds, including across request changes.
- HMASTER_D <= HMASTER on every edge with HREADY=1.
- State IDLE:
  - No requests: stay in IDLE.
  - Any M_HBUSREQ bit set (and HREADY=1): pick winner w. Next edge: M_HGRANT=1<<w, HMASTER=w, arb_busy=1, counter=0, state OWNED.
  - Request-to-grant latency is one cycle.
- State OWNED (owner o):
  - Counter: increments per HREADY cycle, saturating at MAX_HOLD.
  - Owner drops M_HBUSREQ[o], others requesting: grant moves directly to the next winner in one edge (no idle cycle). Counter resets.
  - Owner drops M_HBUSREQ[o], nobody else requesting: go to IDLE. M_HGRANT=0, HMASTER=DEFAULT_MASTER, arb_busy=0.
  - Owner keeps requesting, MAX_HOLD!=0, counter==MAX_HOLD-1, another master requesting: preempt. Re-arbitrate excluding o, grant the winner, counter=0. Master o stays pending and competes normally afterwards.
  - Owner keeps requesting, no competitor: holds indefinitely. Counter saturates, no preemption.
- Winner selection: see Optional Feature. Requests from indices >= NUM_MASTERS do not exist. Exactly one M_HGRANT bit is set, or none.
- Simultaneous events:
  - Owner release and a new request on the same edge: the handover rule applies.
  - Preemption and owner release on the same edge: treated as a release.

Optional Feature:
- Macro: AHB_ARB_ROUND_ROBIN_EN.
- Defined: round-robin selection.
  - Search starts at priority pointer p and wraps modulo NUM_MASTERS.
  - After each grant to w, p <= (w+1) mod NUM_MASTERS.
  - Preemption also uses p, with the owner masked.
- Undefined: fixed priority, lowest index wins. The pointer is absent. Preemption picks the lowest-index requester other than the owner.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no requests -> M_HGRANT=00, HMASTER=0, HMASTER_D=0, arb_busy=0. Values stay constant for 10 cycles.
- Single request: NUM_MASTERS=2, M_HBUSREQ=10 at cycle 0 -> M_HGRANT=10, HMASTER=1 after edge 1, HMASTER_D=1 after edge 2. Drop request -> M_HGRANT=00, HMASTER=0 next edge.
- HREADY stall: master 0 owns, master 1 requests, master 0 releases while HREADY=0 for 3 cycles -> grant unchanged for 3 cycles. Switches to M_HGRANT=10 on the first HREADY=1 edge.
- Preemption: MAX_HOLD=4, masters 0 and 1 request continuously, HREADY=1 -> grant alternates: 0 held 4 cycles, then 1 held 4 cycles, repeating. With MAX_HOLD=0, master 0 holds forever.
- Simultaneous request: NUM_MASTERS=4, M_HBUSREQ=1111 from IDLE:
  - With AHB_ARB_ROUND_ROBIN_EN, each master releasing after 1 cycle -> grant order 0,1,2,3,0.
  - Without the macro, releasing masters re-request each time -> grant is always 0.
- Reset mid-tenure: master 2 owns, rst=1 for one cycle -> M_HGRANT=0000, HMASTER=0, arb_busy=0 next edge. With requests still present after rst=0, a fresh grant appears one edge later.
